eh2_lsu_ecc_wb: RTL and testbench

EH2_LSU_ECC_WB -- requirements
Module: eh2_lsu_ecc_wb

---
 rtl/eh2_pkg.sv | 37 +++
 rtl/eh2_lsu_ecc_wb_rvecc_encode.sv | 22 ++
 rtl/eh2_lsu_ecc_wb.sv | 154 +++++++++++++++
 tb/tb_eh2_lsu_ecc_wb.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eh2_pkg.sv
// Shared types for the LSU ECC write-back path: beat FSM states, correction queue entry and
// the Hamming column masks used by the DCCM ECC encoder.
package eh2_pkg;

   localparam int PKG_DCCM_BITS       = 16;
   localparam int PKG_DCCM_DATA_WIDTH = 32;
   localparam int PKG_DCCM_ECC_WIDTH  = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR_LO = 2'd1,
      WR_HI = 2'd2
   } wb_state_e;

   typedef struct packed {
      logic [PKG_DCCM_BITS-1:0]       addr_lo;
      logic [PKG_DCCM_BITS-1:0]       addr_hi;
      logic [PKG_DCCM_DATA_WIDTH-1:0] data_lo;
      logic [PKG_DCCM_DATA_WIDTH-1:0] data_hi;
      logic                           lo_en;
      logic                           hi_en;
   } wb_entry_t;

   // Data bits occupy the non-power-of-two codeword positions starting at 3; check bit b
   // covers every data bit whose codeword position has bit b set.
   function automatic logic [PKG_DCCM_DATA_WIDTH-1:0] hamming_mask(input int b);
      int p;
      hamming_mask = '0;
      p = 2;
      for (int d = 0; d < PKG_DCCM_DATA_WIDTH; d++) begin
         while ((p & (p - 1)) == 0) p = p + 1;
         hamming_mask[d] = (((p >> b) & 1) != 0);
         p = p + 1;
      end
   endfunction

endpackage

// File: rtl/eh2_lsu_ecc_wb_rvecc_encode.sv
// DCCM SEC-DED encoder: Hamming check bits plus an overall parity bit in the MSB.
// Purely combinational; identical encoding to the DCCM store path.
module rvecc_encode
   import eh2_pkg::*;
#(
   parameter int DW = PKG_DCCM_DATA_WIDTH,
   parameter int EW = PKG_DCCM_ECC_WIDTH
)(
   input  logic [DW-1:0] i_din,
   output logic [EW-1:0] o_ecc
);

   logic [EW-2:0] w_chk;

   for (genvar b = 0; b < EW - 1; b++) begin : g_chk
      localparam logic [DW-1:0] MASK = hamming_mask(b);
      assign w_chk[b] = ^(i_din & MASK);
   end

   assign o_ecc = {^{i_din, w_chk}, w_chk};

endmodule

// File: rtl/eh2_lsu_ecc_wb.sv
// Correction write-back queue: buffers SEC-corrected DCCM loads and rewrites each bank with fresh ECC.
// Push to first request takes 2 cycles, one beat per grant; pushes into a full queue are dropped and flag wb_overflow.
module eh2_lsu_ecc_wb
   import eh2_pkg::*;
#(
   parameter int DCCM_BITS       = PKG_DCCM_BITS,
   parameter int DCCM_DATA_WIDTH = PKG_DCCM_DATA_WIDTH,
   parameter int DCCM_ECC_WIDTH  = PKG_DCCM_ECC_WIDTH,
   parameter int DEPTH           = 4
)(
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      i_corr_valid,
   input  logic                                      i_corr_lo_en,
   input  logic                                      i_corr_hi_en,
   input  logic [DCCM_BITS-1:0]                      i_corr_addr_lo,
   input  logic [DCCM_BITS-1:0]                      i_corr_addr_hi,
   input  logic [DCCM_DATA_WIDTH-1:0]                i_corr_data_lo,
   input  logic [DCCM_DATA_WIDTH-1:0]                i_corr_data_hi,
   output logic                                      o_corr_ready,
   input  logic                                      i_ecc_disable,
   input  logic                                      i_flush,
   output logic                                      o_dccm_wr_req,
   input  logic                                      i_dccm_wr_gnt,
   output logic [DCCM_BITS-1:0]                      o_dccm_wr_addr,
   output logic [DCCM_DATA_WIDTH+DCCM_ECC_WIDTH-1:0] o_dccm_wr_data,
   output logic                                      o_wb_busy,
   output logic                                      o_wb_overflow
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_INC = (AW + 1)'(1);

   wb_entry_t                  r_q [DEPTH];
   logic [AW:0]                r_wptr;
   logic [AW:0]                r_rptr;
   wb_state_e                  r_state;
   logic                       r_wr_req;
   logic                       r_overflow;

   wb_state_e                  w_state_nxt;
   wb_entry_t                  w_new;
   wb_entry_t                  w_head;
   logic [AW:0]                w_count;
   logic                       w_full;
   logic                       w_empty;
   logic                       w_any_en;
   logic                       w_push;
   logic                       w_pop;
   logic [DCCM_BITS-1:0]       w_bank_addr;
   logic [DCCM_DATA_WIDTH-1:0] w_bank_data;
   logic [DCCM_ECC_WIDTH-1:0]  w_ecc;

   assign w_count  = r_wptr - r_rptr;
   assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_empty  = (r_wptr == r_rptr);
   assign w_any_en = i_corr_lo_en | i_corr_hi_en;

   // Readiness comes only from the registered pointers, so a same-cycle pop never frees a slot early.
   assign w_push = i_corr_valid & ~w_full & ~i_flush & ~i_ecc_disable & w_any_en;

   assign w_new.addr_lo = i_corr_addr_lo;
   assign w_new.addr_hi = i_corr_addr_hi;
   assign w_new.data_lo = i_corr_data_lo;
   assign w_new.data_hi = i_corr_data_hi;
   assign w_new.lo_en   = i_corr_lo_en;
   assign w_new.hi_en   = i_corr_hi_en;

   assign w_head = r_q[r_rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q[r_wptr[AW-1:0]] <= w_new;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_state_nxt = w_head.lo_en ? WR_LO : WR_HI;
            end
         end
         WR_LO: begin
            if (i_dccm_wr_gnt) begin
               if (w_head.hi_en) begin
                  w_state_nxt = WR_HI;
               end else begin
                  w_pop       = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
         end
         WR_HI: begin
            if (i_dccm_wr_gnt) begin
               w_pop       = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      // Flush wins over everything; a coincident grant is simply absorbed.
      if (i_flush) begin
         w_state_nxt = IDLE;
         w_pop       = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_wr_req   <= 1'b0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_wr_req <= (w_state_nxt != IDLE);
         if (i_flush) begin
            r_rptr <= r_wptr;
         end else if (w_pop) begin
            r_rptr <= r_rptr + PTR_INC;
         end
         if (w_push) begin
            r_wptr <= r_wptr + PTR_INC;
         end
         if (i_corr_valid && w_full && w_any_en) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign w_bank_addr = (r_state == WR_HI) ? w_head.addr_hi : w_head.addr_lo;
   assign w_bank_data = (r_state == WR_HI) ? w_head.data_hi : w_head.data_lo;

   rvecc_encode #(
      .DW (DCCM_DATA_WIDTH),
      .EW (DCCM_ECC_WIDTH)
   ) u_ecc (
      .i_din (w_bank_data),
      .o_ecc (w_ecc)
   );

   // Address/data are forced to zero outside a beat so unreset queue storage never leaks out.
   assign o_dccm_wr_req  = r_wr_req;
   assign o_dccm_wr_addr = r_wr_req ? w_bank_addr : '0;
   assign o_dccm_wr_data = r_wr_req ? {w_ecc, w_bank_data} : '0;
   assign o_corr_ready   = ~w_full;
   assign o_wb_busy      = (w_count != '0) | (r_state != IDLE);
   assign o_wb_overflow  = r_overflow;

endmodule

// File: tb/tb_eh2_lsu_ecc_wb.sv
// Bench for eh2_lsu_ecc_wb: directed scenarios followed by random traffic checked against a
// transaction-level queue model of pending bank write-backs.
module tb_eh2_lsu_ecc_wb;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        corr_valid;
   logic        corr_lo_en;
   logic        corr_hi_en;
   logic [15:0] corr_addr_lo;
   logic [15:0] corr_addr_hi;
   logic [31:0] corr_data_lo;
   logic [31:0] corr_data_hi;
   logic        corr_ready;
   logic        ecc_disable;
   logic        flush;
   logic        dccm_wr_req;
   logic        dccm_wr_gnt;
   logic [15:0] dccm_wr_addr;
   logic [38:0] dccm_wr_data;
   logic        wb_busy;
   logic        wb_overflow;

   eh2_lsu_ecc_wb #(
      .DCCM_BITS       (16),
      .DCCM_DATA_WIDTH (32),
      .DCCM_ECC_WIDTH  (7),
      .DEPTH           (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_corr_valid   (corr_valid),
      .i_corr_lo_en   (corr_lo_en),
      .i_corr_hi_en   (corr_hi_en),
      .i_corr_addr_lo (corr_addr_lo),
      .i_corr_addr_hi (corr_addr_hi),
      .i_corr_data_lo (corr_data_lo),
      .i_corr_data_hi (corr_data_hi),
      .o_corr_ready   (corr_ready),
      .i_ecc_disable  (ecc_disable),
      .i_flush        (flush),
      .o_dccm_wr_req  (dccm_wr_req),
      .i_dccm_wr_gnt  (dccm_wr_gnt),
      .o_dccm_wr_addr (dccm_wr_addr),
      .o_dccm_wr_data (dccm_wr_data),
      .o_wb_busy      (wb_busy),
      .o_wb_overflow  (wb_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        lo;
      logic        hi;
      logic [15:0] alo;
      logic [15:0] ahi;
      logic [31:0] dlo;
      logic [31:0] dhi;
   } ent_t;

   ent_t mdl[$];
   bit   mdl_lo_done;
   bit   mdl_ovf;
   int   checks;
   int   failures;
   int   nbeats;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // SEC-DED code of the DCCM: fixed column masks for the six Hamming bits, overall parity on top.
   function automatic logic [6:0] ecc32(input logic [31:0] d);
      logic [5:0] c;
      c[0] = ^(d & 32'h56AAAD5B);
      c[1] = ^(d & 32'h9B33366D);
      c[2] = ^(d & 32'hE3C3C78E);
      c[3] = ^(d & 32'h03FC07F0);
      c[4] = ^(d & 32'h03FFF800);
      c[5] = ^(d & 32'hFC000000);
      return {^{d, c}, c};
   endfunction

   function automatic logic [54:0] head_beat();
      ent_t e;
      e = mdl[0];
      if (e.lo && !mdl_lo_done) return {e.alo, ecc32(e.dlo), e.dlo};
      return {e.ahi, ecc32(e.dhi), e.dhi};
   endfunction

   task automatic set_push(input logic lo, input logic hi, input logic [15:0] alo,
                           input logic [15:0] ahi, input logic [31:0] dlo, input logic [31:0] dhi);
      corr_valid   = 1'b1;
      corr_lo_en   = lo;
      corr_hi_en   = hi;
      corr_addr_lo = alo;
      corr_addr_hi = ahi;
      corr_data_lo = dlo;
      corr_data_hi = dhi;
   endtask

   task automatic clr_push();
      corr_valid = 1'b0;
      corr_lo_en = 1'b0;
      corr_hi_en = 1'b0;
   endtask

   // One clock: check the beat on offer, advance the model by this cycle's inputs, then check status.
   task automatic step();
      int   sz0;
      bit   done;
      bit   any;
      ent_t e;
      sz0  = mdl.size();
      done = dccm_wr_req && dccm_wr_gnt;
      any  = corr_lo_en || corr_hi_en;
      if (dccm_wr_req) begin
         if (sz0 == 0) chk("spurious_req", 64'(dccm_wr_req), 64'd0);
         else chk("wr_beat", 64'({dccm_wr_addr, dccm_wr_data}), 64'(head_beat()));
      end
      if (done) nbeats++;
      if (corr_valid && any && sz0 >= DEPTH) mdl_ovf = 1'b1;
      if (flush) begin
         mdl.delete();
         mdl_lo_done = 1'b0;
      end else begin
         if (done && sz0 > 0) begin
            if (mdl[0].lo && mdl[0].hi && !mdl_lo_done) begin
               mdl_lo_done = 1'b1;
            end else begin
               void'(mdl.pop_front());
               mdl_lo_done = 1'b0;
            end
         end
         if (corr_valid && any && !ecc_disable && sz0 < DEPTH) begin
            e.lo  = corr_lo_en;    e.hi  = corr_hi_en;
            e.alo = corr_addr_lo;  e.ahi = corr_addr_hi;
            e.dlo = corr_data_lo;  e.dhi = corr_data_hi;
            mdl.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      chk("corr_ready", 64'(corr_ready), 64'(mdl.size() < DEPTH));
      chk("wb_busy", 64'(wb_busy), 64'(mdl.size() != 0));
      chk("wb_overflow", 64'(wb_overflow), 64'(mdl_ovf));
      if (mdl.size() == 0) chk("req_when_empty", 64'(dccm_wr_req), 64'd0);
   endtask

   task automatic drain(input string tag);
      dccm_wr_gnt = 1'b1;
      for (int k = 0; k < 60 && mdl.size() != 0; k++) step();
      chk(tag, 64'(wb_busy), 64'd0);
   endtask

   initial begin
      logic [4:0]  pat;
      int          nb_saved;
      logic [31:0] d0;

      checks = 0; failures = 0; nbeats = 0;
      mdl_lo_done = 1'b0; mdl_ovf = 1'b0;
      rst = 1'b1;
      clr_push();
      corr_addr_lo = '0; corr_addr_hi = '0; corr_data_lo = '0; corr_data_hi = '0;
      ecc_disable = 1'b0; flush = 1'b0; dccm_wr_gnt = 1'b0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 64'(dccm_wr_req), 64'd0);
      chk("rst_ready", 64'(corr_ready), 64'd1);
      chk("rst_busy", 64'(wb_busy), 64'd0);
      chk("rst_ovf", 64'(wb_overflow), 64'd0);
      chk("rst_addr", 64'(dccm_wr_addr), 64'd0);
      chk("rst_data", 64'(dccm_wr_data), 64'd0);
      rst = 1'b0;

      // Lo-only push into empty queue, grant tied high: request in cycle 2
      dccm_wr_gnt = 1'b1;
      set_push(1'b1, 1'b0, 16'h0100, 16'h0000, 32'h0, 32'h0);
      step();
      chk("lat_c1_req", 64'(dccm_wr_req), 64'd0);
      clr_push();
      step();
      chk("lat_c2_req", 64'(dccm_wr_req), 64'd1);
      chk("lat_c2_addr", 64'(dccm_wr_addr), 64'h0100);
      chk("lat_c2_data", 64'(dccm_wr_data), 64'd0);
      step();
      chk("s1_busy_after", 64'(wb_busy), 64'd0);

      // Lo+hi push with grant withheld: request holds stable, then hi beat, then pop
      dccm_wr_gnt = 1'b0;
      set_push(1'b1, 1'b1, 16'h0104, 16'h0108, 32'hDEADBEEF, 32'h12345678);
      step();
      clr_push();
      step();
      chk("s2_req", 64'(dccm_wr_req), 64'd1);
      chk("s2_data_lo", 64'(dccm_wr_data), 64'({ecc32(32'hDEADBEEF), 32'hDEADBEEF}));
      for (int i = 0; i < 5; i++) begin
         step();
         chk("s2_hold_addr", 64'(dccm_wr_addr), 64'h0104);
      end
      dccm_wr_gnt = 1'b1;
      step();
      chk("s2_hi_req", 64'(dccm_wr_req), 64'd1);
      chk("s2_hi_addr", 64'(dccm_wr_addr), 64'h0108);
      step();
      chk("s2_done_req", 64'(dccm_wr_req), 64'd0);

      // Back-to-back entries: exactly one IDLE cycle between requests
      pat = '0;
      set_push(1'b1, 1'b0, 16'h0110, 16'h0, 32'h1111_0000, 32'h0);
      step(); pat = {pat[3:0], dccm_wr_req};
      set_push(1'b1, 1'b0, 16'h0114, 16'h0, 32'h2222_0000, 32'h0);
      step(); pat = {pat[3:0], dccm_wr_req};
      clr_push();
      step(); pat = {pat[3:0], dccm_wr_req};
      step(); pat = {pat[3:0], dccm_wr_req};
      step(); pat = {pat[3:0], dccm_wr_req};
      chk("b2b_req_pattern", 64'(pat), 64'b01010);

      // Overflow: fill with grant low, fifth push lost, then drain in order
      dccm_wr_gnt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         d0 = $urandom;
         set_push(1'b1, 1'b0, 16'(16'h0300 + 4 * i), 16'h0, d0, 32'h0);
         step();
         if (i == 2) chk("ovf_ready_after3", 64'(corr_ready), 64'd1);
         if (i == 3) chk("ovf_ready_after4", 64'(corr_ready), 64'd0);
      end
      clr_push();
      chk("ovf_sticky", 64'(wb_overflow), 64'd1);
      nb_saved = nbeats;
      drain("ovf_drain_busy");
      chk("ovf_drain_count", 64'(nbeats - nb_saved), 64'd4);
      chk("ovf_still_set", 64'(wb_overflow), 64'd1);

      // Flush with three entries queued and a coincident grant
      dccm_wr_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_push(1'b1, 1'b1, 16'(16'h0500 + 8 * i), 16'(16'h0504 + 8 * i), $urandom, $urandom);
         step();
      end
      clr_push();
      step();
      flush = 1'b1;
      dccm_wr_gnt = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_req", 64'(dccm_wr_req), 64'd0);
      chk("flush_busy", 64'(wb_busy), 64'd0);
      nb_saved = nbeats;
      repeat (4) step();
      chk("flush_no_writes", 64'(nbeats - nb_saved), 64'd0);

      // Pushes ignored under ecc_disable or with no bank enabled
      ecc_disable = 1'b1;
      set_push(1'b1, 1'b0, 16'h0600, 16'h0, 32'hA5A5A5A5, 32'h0);
      step();
      clr_push();
      step();
      chk("eccdis_busy", 64'(wb_busy), 64'd0);
      chk("eccdis_req", 64'(dccm_wr_req), 64'd0);
      ecc_disable = 1'b0;
      set_push(1'b0, 1'b0, 16'h0604, 16'h0608, 32'h1, 32'h2);
      step();
      step();
      clr_push();
      chk("noen_busy", 64'(wb_busy), 64'd0);
      chk("noen_req", 64'(dccm_wr_req), 64'd0);

      // ecc_disable raised after enqueue does not abort the drain
      dccm_wr_gnt = 1'b0;
      set_push(1'b1, 1'b0, 16'h0700, 16'h0, 32'hCAFEF00D, 32'h0);
      step();
      clr_push();
      ecc_disable = 1'b1;
      step();
      nb_saved = nbeats;
      drain("eccdis_drain_busy");
      chk("eccdis_drain_count", 64'(nbeats - nb_saved), 64'd1);
      ecc_disable = 1'b0;

      // Reset pulse while in the hi beat
      dccm_wr_gnt = 1'b0;
      set_push(1'b1, 1'b1, 16'h0200, 16'h0204, $urandom, $urandom);
      step();
      clr_push();
      step();
      dccm_wr_gnt = 1'b1;
      step();
      dccm_wr_gnt = 1'b0;
      chk("pre_rst_addr", 64'(dccm_wr_addr), 64'h0204);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_req", 64'(dccm_wr_req), 64'd0);
      chk("mid_rst_addr", 64'(dccm_wr_addr), 64'd0);
      chk("mid_rst_data", 64'(dccm_wr_data), 64'd0);
      chk("mid_rst_ready", 64'(corr_ready), 64'd1);
      chk("mid_rst_busy", 64'(wb_busy), 64'd0);
      chk("mid_rst_ovf", 64'(wb_overflow), 64'd0);
      mdl.delete();
      mdl_lo_done = 1'b0;
      mdl_ovf = 1'b0;
      #1 rst = 1'b0;
      dccm_wr_gnt = 1'b1;
      nb_saved = nbeats;
      repeat (4) step();
      chk("post_rst_no_writes", 64'(nbeats - nb_saved), 64'd0);

      // Random traffic against the model
      for (int c = 0; c < 800; c++) begin
         corr_valid   = ($urandom_range(0, 99) < 60);
         corr_lo_en   = ($urandom_range(0, 99) < 70);
         corr_hi_en   = ($urandom_range(0, 99) < 50);
         corr_addr_lo = 16'($urandom);
         corr_addr_hi = 16'($urandom);
         corr_data_lo = $urandom;
         corr_data_hi = $urandom;
         dccm_wr_gnt  = ($urandom_range(0, 99) < 45);
         flush        = ($urandom_range(0, 99) < 2);
         ecc_disable  = ($urandom_range(0, 99) < 5);
         step();
      end
      clr_push();
      flush = 1'b0;
      ecc_disable = 1'b0;
      drain("rand_drain_busy");
      chk("rand_final_req", 64'(dccm_wr_req), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
